dump_ctrl: RTL
==============

# dump_ctrl

Post-capture dump engine for the scope datapath. It sits directly downstream of the capture controller. Once a capture completes, it reads one channel's circular sample RAM in chronological order, oldest sample first, starting one past `trace_end`. It hands each byte to the UART transmitter through a `trmt`/`tx_done` handshake and pulses `dump_finished` after the last byte.

## Interface
- `ADDR_W`, default 9: RAM address width. Depth is 2^ADDR_W (512).
- `DATA_W`, default 8: sample width, equal to the UART byte width.
- `clk` in 1: system clock; all logic is posedge.
- `rst_n` in 1: reset, asynchronous, active-low. Clock is `clk`.
- `start_dump` in 1: one-cycle dump request. Sampled only in IDLE.
- `dump_channel` in 2: channel select. 00=CH1, 01=CH2, 10=CH3, 11=invalid. Latched with `start_dump`.
- `trace_end` in ADDR_W: address of the last sample written by capture. Latched with `start_dump`.
- `ram_en` out 1: RAM read enable, one cycle per byte.
- `ram_addr` out ADDR_W: read address, shared by all channel RAMs.
- `rdata_ch1`, `rdata_ch2`, `rdata_ch3` in DATA_W: RAM read data, valid exactly one cycle after `ram_en`.
- `tx_data` out DATA_W: byte to transmit. Held stable from `trmt` until `tx_done`.
- `trmt` out 1: one-cycle transmit-start pulse.
- `tx_done` in 1: UART byte-complete pulse.
- `send_dump` out 1: high while a dump is in progress (state not IDLE).
- `dump_finished` out 1: one-cycle pulse when a dump ends.

## Operation
- States:
  - IDLE: waits for a request.
  - READ: `ram_en`=1 at the current `ram_addr`.
  - LATCH: registers the selected channel's `rdata` into `tx_data`.
  - SEND: `trmt`=1 for one cycle.
  - WAIT_TX: holds until `tx_done`.
  - FIN: `dump_finished`=1, then returns to IDLE.
- IDLE, `start_dump`=1, valid channel:
  - latch the channel;
  - `ram_addr` <= `trace_end`+1, mod 2^ADDR_W;
  - `smpl_cnt` <= 0;
  - go to READ.
- IDLE, `start_dump`=1, channel 11: go straight to FIN. No RAM reads, no `trmt`.
- READ -> LATCH -> SEND -> WAIT_TX unconditionally.
- WAIT_TX, `tx_done`=1:
  - if `smpl_cnt`==2^ADDR_W-1, go to FIN;
  - otherwise `smpl_cnt`++, `ram_addr`++ (wrapping 511 -> 0), go to READ.
- FIN -> IDLE.
- Exactly 2^ADDR_W bytes are sent per dump, in order `trace_end`+1, …, 511, 0, …, `trace_end`.
- `trace_end`=511 gives addresses 0..511 with no wrap.
- `trace_end` and `dump_channel` changing mid-dump have no effect; both are latched.
- `start_dump` outside IDLE is ignored and is not queued.
- `tx_done` outside WAIT_TX is ignored. This includes `tx_done` in the same cycle as `trmt`.
- Counter widths:
  - `smpl_cnt` is ADDR_W bits;
  - address increment truncates to ADDR_W bits, which gives the wrap-around for free.

## Timing
- Reset values: `ram_en`=0, `ram_addr`=0, `tx_data`=0, `trmt`=0, `send_dump`=0, `dump_finished`=0, state IDLE, `smpl_cnt`=0.
- `rst_n` low mid-dump aborts immediately: all outputs return to reset values and no `dump_finished` pulse is produced.
- All outputs are registered or decoded from registered state only. There are no combinational input-to-output paths.
- Cycle map, with `start_dump` sampled high at edge N:
  - N+1: READ;
  - N+2: LATCH;
  - N+3: SEND (`trmt`=1, `tx_data` valid).
- Per-byte cost is 3 cycles plus the UART latency. The next READ follows the `tx_done` edge by exactly one cycle.
- `dump_finished` is high for one cycle, one cycle after the final `tx_done`. `send_dump` drops in the following cycle (IDLE).
- Invalid channel: `dump_finished` at N+1 and `send_dump`=1 for that single cycle only.

## Structure
- Shared package `capture_pkg` holds:
  - the `Address` typedef (ADDR_W-bit);
  - the `DumpState` enum;
  - the channel-select constants CH1/CH2/CH3/CH_INV.
- `capture_pkg` is also imported by the capture controller.
- One sub-module, `dump_addr_gen`:
  - inputs: load, `trace_end`, step;
  - outputs: `ram_addr`, `last` (high when `smpl_cnt` is at its maximum);
  - contains the wrapping address register and the sample counter.
- The top level holds the FSM, the channel mux and the `tx_data` register.

## Test plan
- Run with ADDR_W=9 and RAMs preloaded with CH1[i]=i[7:0], CH2[i]=~i[7:0], CH3[i]=0xA5 ^ i[7:0]. The UART model returns `tx_done` 10 cycles after `trmt`.
- Basic wrap:
  - stimulus: `trace_end`=100, channel 00, `start_dump`;
  - required: 512 `trmt` pulses with bytes 101..255, then 0x00..0xFF for addresses 256..511, then 0..100 (as 8-bit values);
  - required: one `dump_finished` pulse, and `send_dump` is low afterwards.
- No-wrap edge:
  - stimulus: `trace_end`=511, channel 10;
  - required: first `ram_addr`=0, last `ram_addr`=511, first byte 0xA5, 512 bytes total.
- Ignored inputs:
  - stimulus: during a dump, pulse `start_dump`, change `dump_channel` and `trace_end`, and inject a spurious `tx_done` in a SEND cycle;
  - required: byte stream identical to the clean run and exactly one `dump_finished`.
- Invalid channel:
  - stimulus: `dump_channel`=11, `start_dump` at edge N;
  - required: `dump_finished`=1 at N+1, `ram_en` and `trmt` never asserted.
- Reset mid-dump:
  - stimulus: assert `rst_n` low after 37 bytes sent;
  - required: all outputs 0 immediately and no `dump_finished` pulse;
  - required: a new dump with `trace_end`=0, channel 01, sends first byte 0xFE and then a full 512-byte stream.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg: types and constants shared by the capture controller and the
// post-capture dump engine.
//   Address   - sample RAM address (default 9 bits, 512 samples)
//   DumpState - dump engine FSM states
//   CH1..CH_INV - 2-bit channel-select codes
package capture_pkg;

  localparam int CAP_ADDR_W = 9;

  typedef logic [CAP_ADDR_W-1:0] Address;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SEND,
    WAIT_TX,
    FIN
  } DumpState;

  localparam logic [1:0] CH1    = 2'b00;
  localparam logic [1:0] CH2    = 2'b01;
  localparam logic [1:0] CH3    = 2'b10;
  localparam logic [1:0] CH_INV = 2'b11;

endpackage

// File: rtl/dump_addr_gen.sv
// dump_addr_gen: wrapping read-address register plus sample counter for the
// dump engine.
//   clk, rst_n : clock, async active-low reset
//   load       : start of dump, address <= trace_end+1, counter <= 0
//   trace_end  : last address written by capture
//   step       : advance to the next sample
//   ram_addr   : current read address
//   last       : counter is at its maximum (final sample of the dump)
module dump_addr_gen
  import capture_pkg::*;
#(
  parameter int ADDR_W = $bits(Address)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] trace_end,
  input  logic              step,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              last
);

  logic [ADDR_W-1:0] smpl_cnt;

  // Address arithmetic truncates to ADDR_W bits, so the circular buffer
  // wraps from the top address back to zero without extra logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr <= '0;
      smpl_cnt <= '0;
    end else if (load) begin
      ram_addr <= trace_end + ADDR_W'(1);
      smpl_cnt <= '0;
    end else if (step) begin
      ram_addr <= ram_addr + ADDR_W'(1);
      smpl_cnt <= smpl_cnt + ADDR_W'(1);
    end
  end

  assign last = &smpl_cnt;

endmodule

// File: rtl/dump_ctrl.sv
// dump_ctrl: post-capture dump engine. Reads one channel's circular sample
// RAM oldest-first (starting one past trace_end) and hands each byte to the
// UART with a trmt/tx_done handshake.
//   start_dump, dump_channel, trace_end : dump request (sampled in IDLE only)
//   ram_en, ram_addr                    : shared RAM read port
//   rdata_ch1..3                        : RAM data, one cycle after ram_en
//   tx_data, trmt, tx_done              : UART handshake
//   send_dump                           : dump in progress
//   dump_finished                       : one-cycle end-of-dump pulse
module dump_ctrl
  import capture_pkg::*;
#(
  parameter int ADDR_W = $bits(Address),
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_dump,
  input  logic [1:0]        dump_channel,
  input  logic [ADDR_W-1:0] trace_end,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] rdata_ch1,
  input  logic [DATA_W-1:0] rdata_ch2,
  input  logic [DATA_W-1:0] rdata_ch3,
  output logic [DATA_W-1:0] tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic              send_dump,
  output logic              dump_finished
);

  DumpState          state, state_nxt;
  logic [1:0]        ch_q;
  logic              load, step, last;
  logic [DATA_W-1:0] rdata_sel;

  dump_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .trace_end(trace_end),
    .step     (step),
    .ram_addr (ram_addr),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // tx_done is only honoured in WAIT_TX, so a pulse coinciding with trmt
  // cannot skip a byte.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE:
        if (start_dump) begin
          if (dump_channel == CH_INV) begin
            state_nxt = FIN;
          end else begin
            state_nxt = READ;
            load      = 1'b1;
          end
        end
      READ:  state_nxt = LATCH;
      LATCH: state_nxt = SEND;
      SEND:  state_nxt = WAIT_TX;
      WAIT_TX:
        if (tx_done) begin
          if (last) begin
            state_nxt = FIN;
          end else begin
            state_nxt = READ;
            step      = 1'b1;
          end
        end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (ch_q)
      CH1:     rdata_sel = rdata_ch1;
      CH2:     rdata_sel = rdata_ch2;
      CH3:     rdata_sel = rdata_ch3;
      default: rdata_sel = '0;
    endcase
  end

  // Channel is captured with the request so mid-dump changes are ignored;
  // tx_data only moves in LATCH, which keeps it stable through WAIT_TX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q    <= CH1;
      tx_data <= '0;
    end else begin
      if (state == IDLE && start_dump) ch_q <= dump_channel;
      if (state == LATCH)              tx_data <= rdata_sel;
    end
  end

  assign ram_en        = (state == READ);
  assign trmt          = (state == SEND);
  assign send_dump     = (state != IDLE);
  assign dump_finished = (state == FIN);

endmodule
